// File: rtl/prime_sequence_checker_pkg.sv
// rtl/prime_sequence_checker_pkg.sv - shared prime table, index bounds and state encodings
package prime_sequence_checker_pkg;

  // The six primes produced by the counter, in ascending order.
  localparam int unsigned PRIME_0 = 2;
  localparam int unsigned PRIME_1 = 3;
  localparam int unsigned PRIME_2 = 5;
  localparam int unsigned PRIME_3 = 7;
  localparam int unsigned PRIME_4 = 11;
  localparam int unsigned PRIME_5 = 13;

  localparam logic [2:0] IDX_FIRST = 3'd0;
  localparam logic [2:0] IDX_LAST  = 3'd5;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Index the counter should present next; it holds at either end instead of wrapping.
  function automatic logic [2:0] next_index(input logic [2:0] idx, input logic dir_down);
    if (dir_down) begin
      next_index = (idx == IDX_FIRST) ? IDX_FIRST : idx - 3'd1;
    end else begin
      next_index = (idx == IDX_LAST) ? IDX_LAST : idx + 3'd1;
    end
  endfunction

endpackage

// File: rtl/prime_index_lookup.sv
// rtl/prime_index_lookup.sv - maps a sampled number to its position in the prime table
module prime_index_lookup
  import prime_sequence_checker_pkg::*;
#(
  parameter int NUM_W = 5
) (
  input  logic [0:NUM_W-1] i_number,
  output logic             o_is_prime,
  output logic [2:0]       o_idx
);

  // Table match; anything outside the six primes reports is_prime=0 with idx 0.
  always_comb begin
    o_is_prime = 1'b1;
    o_idx      = 3'd0;
    case (i_number)
      NUM_W'(PRIME_0): o_idx = 3'd0;
      NUM_W'(PRIME_1): o_idx = 3'd1;
      NUM_W'(PRIME_2): o_idx = 3'd2;
      NUM_W'(PRIME_3): o_idx = 3'd3;
      NUM_W'(PRIME_4): o_idx = 3'd4;
      NUM_W'(PRIME_5): o_idx = 3'd5;
      default:         o_is_prime = 1'b0;
    endcase
  end

endmodule

// File: rtl/prime_sequence_checker.sv
// rtl/prime_sequence_checker.sv - locks onto the prime counter sequence and flags violations
module prime_sequence_checker
  import prime_sequence_checker_pkg::*;
#(
  parameter int NUM_W     = 5,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_sample_en,
  input  logic [0:NUM_W-1]     i_number,
  output logic                 o_locked,
  output logic                 o_direction,
  output logic [2:0]           o_index,
  output logic                 o_error,
  output logic [ERR_CNT_W-1:0] o_error_count
);

  state_t               r_state;
  logic                 r_locked;
  logic                 r_direction;
  logic [2:0]           r_index;
  logic                 r_error;
  logic [ERR_CNT_W-1:0] r_error_count;

  logic       w_is_prime;
  logic [2:0] w_idx;
  logic [2:0] w_expected;
  logic       w_sync_up;
  logic       w_sync_down;
  logic       w_sync_hold_last;
  logic       w_sync_hold_first;
  logic       w_sync_ok;
  logic       w_violation;

  prime_index_lookup #(
    .NUM_W(NUM_W)
  ) u_lookup (
    .i_number  (i_number),
    .o_is_prime(w_is_prime),
    .o_idx     (w_idx)
  );

  // In SYNC, a neighbouring prime fixes the direction; a repeat is only legal at
  // an end of the table, where the counter saturates and holds its value.
  assign w_sync_up         = (w_idx == r_index + 3'd1);
  assign w_sync_down       = (w_idx == r_index - 3'd1);
  assign w_sync_hold_last  = (w_idx == r_index) && (r_index == IDX_LAST);
  assign w_sync_hold_first = (w_idx == r_index) && (r_index == IDX_FIRST);
  assign w_sync_ok         = w_sync_up || w_sync_down || w_sync_hold_last || w_sync_hold_first;

  assign w_expected = next_index(r_index, r_direction);

  // HUNT never flags: until a prime has been seen there is no sequence to violate.
  always_comb begin
    w_violation = 1'b0;
    if (i_sample_en) begin
      case (r_state)
        ST_SYNC:   w_violation = !w_is_prime || !w_sync_ok;
        ST_LOCKED: w_violation = !w_is_prime || (w_idx != w_expected);
        default:   w_violation = 1'b0;
      endcase
    end
  end

  // Sequence FSM with registered locked/direction/index/error outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_HUNT;
      r_locked    <= 1'b0;
      r_direction <= 1'b0;
      r_index     <= IDX_FIRST;
      r_error     <= 1'b0;
    end else if (!i_sample_en) begin
      r_error <= 1'b0;
    end else begin
      r_error <= w_violation;
      case (r_state)
        ST_HUNT: begin
          if (w_is_prime) begin
            r_state <= ST_SYNC;
            r_index <= w_idx;
          end
        end
        ST_SYNC: begin
          if (!w_is_prime) begin
            r_state <= ST_HUNT;
          end else begin
            r_index <= w_idx;
            if (w_sync_up || w_sync_hold_last) begin
              r_state     <= ST_LOCKED;
              r_locked    <= 1'b1;
              r_direction <= 1'b0;
            end else if (w_sync_down || w_sync_hold_first) begin
              r_state     <= ST_LOCKED;
              r_locked    <= 1'b1;
              r_direction <= 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (!w_is_prime) begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
          end else begin
            r_index <= w_idx;
            if (w_idx != w_expected) begin
              // Counter reset or reversal: re-derive the direction from the next sample.
              r_state  <= ST_SYNC;
              r_locked <= 1'b0;
            end
          end
        end
        default: begin
          r_state  <= ST_HUNT;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  // Violation counter, pinned at all ones once full.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_error_count <= '0;
    end else if (w_violation && (r_error_count != {ERR_CNT_W{1'b1}})) begin
      r_error_count <= r_error_count + ERR_CNT_W'(1);
    end
  end

  assign o_locked      = r_locked;
  assign o_direction   = r_direction;
  assign o_index       = r_index;
  assign o_error       = r_error;
  assign o_error_count = r_error_count;

endmodule

// File: tb/tb_prime_sequence_checker.sv
// tb/tb_prime_sequence_checker.sv - directed and randomized checks against a behavioural model
module tb_prime_sequence_checker;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sample_en = 1'b0;
  logic [0:4] number = '0;

  logic       locked_a, direction_a, error_a;
  logic [2:0] index_a;
  logic [7:0] count_a;
  logic       locked_b, direction_b, error_b;
  logic [2:0] index_b;
  logic [1:0] count_b;

  int n_checks = 0;
  int n_errors = 0;

  int primes [6] = '{2, 3, 5, 7, 11, 13};

  // Model state: 0 = hunting, 1 = syncing, 2 = locked
  int m_state, m_index, m_dir, m_err, m_cnt8, m_cnt2;

  always #5 clock = ~clock;

  prime_sequence_checker #(.NUM_W(5), .ERR_CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .i_sample_en(sample_en), .i_number(number),
    .o_locked(locked_a), .o_direction(direction_a), .o_index(index_a),
    .o_error(error_a), .o_error_count(count_a)
  );

  prime_sequence_checker #(.NUM_W(5), .ERR_CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .i_sample_en(sample_en), .i_number(number),
    .o_locked(locked_b), .o_direction(direction_b), .o_index(index_b),
    .o_error(error_b), .o_error_count(count_b)
  );

  function automatic int prime_pos(int n);
    for (int k = 0; k < 6; k++) if (primes[k] == n) return k;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_index = 0; m_dir = 0; m_err = 0; m_cnt8 = 0; m_cnt2 = 0;
  endtask

  task automatic model_step(input int en, input int n);
    int p, want;
    m_err = 0;
    if (en == 0) return;
    p = prime_pos(n);
    if (m_state == 0) begin
      if (p >= 0) begin m_state = 1; m_index = p; end
    end else if (m_state == 1) begin
      if (p < 0) begin m_err = 1; m_state = 0; end
      else begin
        if (p == m_index + 1 || (p == m_index && m_index == 5)) begin m_state = 2; m_dir = 0; end
        else if (p == m_index - 1 || (p == m_index && m_index == 0)) begin m_state = 2; m_dir = 1; end
        else m_err = 1;
        m_index = p;
      end
    end else begin
      want = m_dir ? ((m_index > 0) ? m_index - 1 : 0) : ((m_index < 5) ? m_index + 1 : 5);
      if (p < 0) begin m_err = 1; m_state = 0; end
      else begin
        if (p != want) begin m_err = 1; m_state = 1; end
        m_index = p;
      end
    end
    if (m_err) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".locked"},    locked_a,    (m_state == 2) ? 1 : 0);
    chk({tag, ".direction"}, direction_a, m_dir);
    chk({tag, ".index"},     index_a,     m_index);
    chk({tag, ".error"},     error_a,     m_err);
    chk({tag, ".count8"},    count_a,     m_cnt8);
    chk({tag, ".count2"},    count_b,     m_cnt2);
    chk({tag, ".locked_b"},  locked_b,    (m_state == 2) ? 1 : 0);
  endtask

  task automatic step(input int en, input int n, input string tag);
    sample_en = en[0];
    number    = 5'(n);
    @(posedge clock);
    #1;
    model_step(en, n);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    check_all(tag);
  endtask

  initial begin
    int up_run [7]   = '{2, 3, 5, 7, 11, 13, 13};
    int down_run [7] = '{13, 11, 7, 5, 3, 2, 2};
    int n, p;

    // 1: up run
    sample_en = 1'b1;
    number    = 5'd7;
    do_reset("reset");
    chk("reset.all_zero", {locked_a, direction_a, index_a, error_a, count_a}, 0);
    foreach (up_run[i]) step(1, up_run[i], "up");
    chk("up.final_index", index_a, 5);
    chk("up.final_locked", locked_a, 1);

    // 2: down run
    do_reset("reset2");
    foreach (down_run[i]) step(1, down_run[i], "down");
    chk("down.final_dir", direction_a, 1);
    chk("down.final_index", index_a, 0);
    chk("down.final_count", count_a, 0);

    // 3: locked up at 7, then counter reset to 13 and reversal
    do_reset("reset3");
    step(1, 2, "t3"); step(1, 3, "t3"); step(1, 5, "t3"); step(1, 7, "t3");
    step(1, 13, "t3.jump");
    chk("t3.jump_error", error_a, 1);
    chk("t3.jump_unlocked", locked_a, 0);
    step(1, 11, "t3.relock");
    chk("t3.relock_locked", locked_a, 1);
    chk("t3.relock_dir", direction_a, 1);
    chk("t3.relock_index", index_a, 4);
    chk("t3.count", count_a, 1);

    // 4: non-prime drops to HUNT, further garbage is silent, then relock up
    step(1, 4, "t4.bad");
    chk("t4.bad_error", error_a, 1);
    step(1, 4, "t4.hunt"); step(1, 9, "t4.hunt");
    chk("t4.hunt_count", count_a, 2);
    step(1, 2, "t4.sync"); step(1, 3, "t4.relock");
    chk("t4.relock_dir", direction_a, 0);
    chk("t4.relock_locked", locked_a, 1);

    // 5: sample_en low holds everything, then reset mid-run
    for (int i = 0; i < 3; i++) step(0, $urandom_range(0, 31), "t5.hold");
    chk("t5.hold_index", index_a, 1);
    sample_en = 1'b1;
    number    = 5'd5;
    do_reset("t5.reset");
    chk("t5.reset_zero", {locked_a, direction_a, index_a, error_a, count_a}, 0);

    // 6: narrow counter saturates at 3
    step(1, 3, "t6");
    for (int i = 0; i < 5; i++) begin
      step(1, 8, "t6.np");
      step(1, 5, "t6.p");
    end
    chk("t6.count2_sat", count_b, 3);
    chk("t6.count8", count_a, 5);

    // Randomized traffic, biased towards the legal next prime
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset("rnd.reset");
        continue;
      end
      p = $urandom_range(0, 99);
      if (m_state == 2 && p < 70) begin
        n = m_dir ? primes[(m_index > 0) ? m_index - 1 : 0] : primes[(m_index < 5) ? m_index + 1 : 5];
      end else if (p < 85) begin
        n = primes[$urandom_range(0, 5)];
      end else begin
        n = $urandom_range(0, 31);
      end
      step(($urandom_range(0, 9) == 0) ? 0 : 1, n, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
